// File: rtl/tcore_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tcore_regfile
//  Description : Integer register file with a write-pending scoreboard.
//                x0 is hard-wired to zero. There are two combinational read
//                ports with optional same-cycle forwarding of the write-back
//                value. One pending bit per register marks the destinations
//                of issued long-latency ops, so decode can stall on RAW
//                hazards.
//
//  Ports
//    clk_i          : clock, rising edge
//    rst_i          : asynchronous active-high reset
//    rs1/rs2_addr_i : read addresses
//    rs1/rs2_data_o : read data (combinational)
//    rs1/rs2_busy_o : source register has an outstanding long-latency write
//    rf_rw_en_i     : write-back enable (already stall-gated)
//    rd_addr_i      : write-back destination
//    wb_data_i      : write-back data
//    issue_en_i     : long-latency op with a destination issues this cycle
//    issue_rd_i     : destination of that op
//    flush_i        : clears every pending bit
//    idle_o         : no pending bits set
//    pending_cnt_o  : registered count of pending bits
//
//  Revision    : 1.0 - initial release
// ============================================================================
module tcore_regfile #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [$clog2(NREG)-1:0]   rs1_addr_i,
    input  logic [$clog2(NREG)-1:0]   rs2_addr_i,
    output logic [XLEN-1:0]           rs1_data_o,
    output logic [XLEN-1:0]           rs2_data_o,
    output logic                      rs1_busy_o,
    output logic                      rs2_busy_o,
    input  logic                      rf_rw_en_i,
    input  logic [$clog2(NREG)-1:0]   rd_addr_i,
    input  logic [XLEN-1:0]           wb_data_i,
    input  logic                      issue_en_i,
    input  logic [$clog2(NREG)-1:0]   issue_rd_i,
    input  logic                      flush_i,
    output logic                      idle_o,
    output logic [$clog2(NREG):0]     pending_cnt_o
);

    localparam int   AW  = $clog2(NREG);
    localparam int   CW  = $clog2(NREG) + 1;
    localparam logic BYP = (BYPASS != 0);

    // x0 is never stored, so the array starts at index 1.
    logic [XLEN-1:0] regs [1:NREG-1];
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_next;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_next;

    logic [AW-1:0]   rd_port_addr [2];
    logic [XLEN-1:0] rd_port_data [2];
    logic            rd_port_busy [2];

    assign rd_port_addr[0] = rs1_addr_i;
    assign rd_port_addr[1] = rs2_addr_i;
    assign rs1_data_o      = rd_port_data[0];
    assign rs2_data_o      = rd_port_data[1];
    assign rs1_busy_o      = rd_port_busy[0];
    assign rs2_busy_o      = rd_port_busy[1];

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 1; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (rf_rw_en_i && (rd_addr_i == AW'(r))) begin
                    regs[r] <= wb_data_i;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar p = 0; p < 2; p++) begin : g_read_port
        logic hit;

        always_comb begin
            hit             = BYP && rf_rw_en_i && (rd_addr_i == rd_port_addr[p]);
            rd_port_data[p] = '0;
            if (rd_port_addr[p] != '0) begin
                if (hit) begin
                    rd_port_data[p] = wb_data_i;
                end else begin
                    for (int r = 1; r < NREG; r++) begin
                        if (rd_port_addr[p] == AW'(r)) begin
                            rd_port_data[p] = regs[r];
                        end
                    end
                end
            end
            // pend[0] is constant 0, so x0 can never report busy. A retiring
            // write that is being forwarded is also not busy.
            rd_port_busy[p] = pend[rd_port_addr[p]] && !hit;
        end
    end

    // ------------------------------------------------------------------
    // Pending scoreboard
    // ------------------------------------------------------------------
    always_comb begin
        pend_next = pend;
        if (flush_i) begin
            pend_next = '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (rf_rw_en_i && (rd_addr_i == AW'(r))) begin
                    pend_next[r] = 1'b0;
                end
                // The set is applied after the clear. The issuing op is
                // younger than the one retiring, so its pending bit must
                // survive.
                if (issue_en_i && (issue_rd_i == AW'(r))) begin
                    pend_next[r] = 1'b1;
                end
            end
        end
        pend_next[0] = 1'b0;

        cnt_next = '0;
        for (int r = 1; r < NREG; r++) begin
            cnt_next = cnt_next + CW'(pend_next[r]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend  <= '0;
            cnt_q <= '0;
        end else begin
            pend  <= pend_next;
            cnt_q <= cnt_next;
        end
    end

    assign pending_cnt_o = cnt_q;
    assign idle_o        = (cnt_q == '0);

endmodule
`default_nettype wire

// File: doc/tcore_regfile.md
# tcore_regfile

Integer register file and write-pending scoreboard for the TCORE pipeline. It receives write-back traffic from the write-back stage, which supplies the write enable already gated by stall, plus the selected write data. It serves two combinational read ports to the decode stage, with optional same-cycle write-to-read bypass. A per-register pending bit marks destinations of issued long-latency instructions (load, mul, div) so decode can stall on RAW hazards until write-back retires them.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, number of architectural registers; address width is $clog2(NREG)
- BYPASS, 1, 1 = write-back data is forwarded to read ports in the same cycle; 0 = no forwarding

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, asynchronous, active-high
- rs1_addr_i  in  5  read port 1 address
- rs2_addr_i  in  5  read port 2 address
- rs1_data_o  out  XLEN  read port 1 data
- rs2_data_o  out  XLEN  read port 2 data
- rs1_busy_o  out  1  rs1 has an outstanding long-latency write
- rs2_busy_o  out  1  rs2 has an outstanding long-latency write
- rf_rw_en_i  in  1  write enable from write-back, already stall-gated
- rd_addr_i  in  5  write address from write-back
- wb_data_i  in  XLEN  write data from write-back
- issue_en_i  in  1  a long-latency instruction writing a register issues this cycle
- issue_rd_i  in  5  destination of that instruction
- flush_i  in  1  pipeline flush; clears all pending bits
- idle_o  out  1  no pending bits set
- pending_cnt_o  out  6  number of pending bits set (0..NREG-1)

## Operation
- Storage: regs[1..NREG-1] are flops. Register x0 is not stored; reads of x0 return 0, and writes to x0 are dropped.
- Write: on the clock edge, if rf_rw_en_i && rd_addr_i != 0, then regs[rd_addr_i] <= wb_data_i.
- Read data is combinational:
  - If addr == 0, the result is 0.
  - Otherwise, if BYPASS && rf_rw_en_i && rd_addr_i == addr, the result is wb_data_i.
  - Otherwise, the result is regs[addr].
- Pending bits pend[r] for r in 1..NREG-1, with pend[0] fixed at 0. Next-state priority, highest first:
  1. flush_i: all bits go to 0. A same-cycle issue is also discarded, and a same-cycle write still updates regs.
  2. issue_en_i && issue_rd_i == r && r != 0: pend[r] goes to 1. Set wins over a same-cycle clear of the same r, because the issuing instruction is the younger one.
  3. rf_rw_en_i && rd_addr_i == r: pend[r] goes to 0.
  4. Otherwise pend[r] holds.
- A write-back to a register that is not pending (a short-latency op) leaves its bit at 0 and is legal.
- Busy flags:
  - rsN_busy_o = pend[rsN_addr_i] && !(BYPASS && rf_rw_en_i && rd_addr_i == rsN_addr_i).
  - When BYPASS = 1, the retiring value is forwarded, so the register is not reported busy that cycle.
  - Address 0 is never busy.
- Counter: pending_cnt_o is a registered popcount of the next-state pend vector, updated in the same edge as pend. idle_o = (pending_cnt_o == 0).
- A flush does not cancel in-flight writes. A later write-back to a flushed register updates regs and leaves pend at 0.

## Timing
- Reset, asynchronous: all regs are 0, all pend bits are 0, and pending_cnt_o is 0. This gives rsN_data_o = 0, rsN_busy_o = 0 and idle_o = 1 while rst_i is high, independent of clk_i.
- Reset asserted mid-operation clears state immediately. A write presented in the same cycle as reset is lost.
- Write-to-read latency:
  - BYPASS = 1: 0 cycles (same cycle via bypass).
  - BYPASS = 0: 1 cycle (visible after the edge).
- Issue-to-busy latency: 1 cycle. pend is set at the edge ending the issue cycle.
- Retire-to-not-busy latency:
  - BYPASS = 1: 0 cycles.
  - BYPASS = 0: 1 cycle.
- pending_cnt_o and idle_o change only at clock edges, plus the asynchronous reset.

## Test plan
- Reset then read all addresses: every rsN_data_o = 0, busy = 0, idle_o = 1, pending_cnt_o = 0.
- Write x5 = 0xDEADBEEF with rs1_addr_i = 5 in the same cycle:
  - BYPASS = 1: rs1_data_o = 0xDEADBEEF that cycle.
  - BYPASS = 0: rs1_data_o = 0 that cycle and 0xDEADBEEF the next cycle.
- Write x0 = 0x12345678, then read x0: the result is 0. issue_rd_i = 0 with issue_en_i: pending_cnt_o stays 0.
- Issue x7 (load), then hold rs2_addr_i = 7:
  - rs2_busy_o = 1 from the next cycle, and pending_cnt_o = 1.
  - Write-back of x7 = 0x55 with BYPASS = 1: busy = 0 and data = 0x55 in the same cycle, and idle_o = 1 after the edge.
- Same cycle, issue x3 and write-back x3 (older op): regs[3] is updated, pend[3] = 1, and pending_cnt_o = 1.
- Issue x1, x2, x4 in successive cycles, giving pending_cnt_o = 3. Then assert flush_i together with issue x9: all pend = 0, cnt = 0, idle_o = 1. A later write-back of x2 updates data and cnt stays 0.
